// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle of the programmable down-counting timer
interface countdown_timer_if #(
    parameter int dwidth = 8
);
    logic              en;
    logic              start;
    logic              stop;
    logic              periodic;
    logic [dwidth-1:0] load_value;
    logic [dwidth-1:0] count;
    logic              busy;
    logic              done;

    modport master (
        output en, start, stop, periodic, load_value,
        input  count, busy, done
    );

    modport slave (
        input  en, start, stop, periodic, load_value,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - down-counting timer, one-shot or auto-reload, registered expiry pulse
module countdown_timer #(
    parameter int dwidth = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    countdown_timer_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [dwidth-1:0] ONE = {{(dwidth-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [dwidth-1:0] count_q, count_d;
    logic [dwidth-1:0] reload_q, reload_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // stop beats start beats counting; expiry is the enabled RUN cycle that sees zero
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            state_d  = RUN;
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            mode_d   = bus.periodic;
        end else if (state_q == RUN && bus.en) begin
            if (count_q == '0) begin
                done_d = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - table-driven, queue-scoreboarded bench for countdown_timer
module tb_countdown_timer;
    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    countdown_timer_if #(.dwidth(8)) bus ();

    countdown_timer #(.dwidth(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       en;
        logic       per;
        logic [7:0] load;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic r, input logic s, input logic p, input logic e,
                                input logic m, input int ld, input int c, input logic b,
                                input logic d);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.en = e; v.per = m;
        v.load = 8'(ld); v.cnt = 8'(c); v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic e,
                         input logic m, input logic [7:0] ld);
        @(negedge clk_i);
        reset_i = r; bus.start = s; bus.stop = p; bus.en = e;
        bus.periodic = m; bus.load_value = ld;
    endtask

    initial begin
        exp_t x;
        int first_done, second_done;

        reset_i = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0;
        bus.periodic = 1'b0; bus.load_value = 8'd0;

        //  rst st sp en pr ld   cnt busy done
        add(1, 0, 0, 0, 0, 0,   0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // one-shot, load 3
        add(0, 1, 0, 1, 0, 3,   3, 1, 0);
        add(0, 0, 0, 1, 0, 3,   2, 1, 0);
        add(0, 0, 0, 1, 0, 3,   1, 1, 0);
        add(0, 0, 0, 1, 0, 3,   0, 1, 0);
        add(0, 0, 0, 1, 0, 3,   0, 0, 1);
        add(0, 0, 0, 1, 0, 3,   0, 0, 0);
        add(0, 0, 0, 1, 0, 3,   0, 0, 0);
        // periodic, load 2, load_value changed mid-run
        add(0, 1, 0, 1, 1, 2,   2, 1, 0);
        add(0, 0, 0, 1, 1, 2,   1, 1, 0);
        add(0, 0, 0, 1, 1, 2,   0, 1, 0);
        add(0, 0, 0, 1, 1, 2,   2, 1, 1);
        add(0, 0, 0, 1, 0, 7,   1, 1, 0);
        add(0, 0, 0, 1, 0, 7,   0, 1, 0);
        add(0, 0, 0, 1, 0, 7,   2, 1, 1);
        add(0, 0, 0, 1, 0, 7,   1, 1, 0);
        add(0, 0, 0, 1, 0, 7,   0, 1, 0);
        add(0, 0, 0, 1, 0, 7,   2, 1, 1);
        add(0, 0, 1, 1, 0, 7,   2, 0, 0);
        add(0, 0, 0, 1, 0, 7,   2, 0, 0);
        // en gating
        add(0, 1, 0, 0, 0, 2,   2, 1, 0);
        add(0, 0, 0, 1, 0, 2,   1, 1, 0);
        add(0, 0, 0, 0, 0, 2,   1, 1, 0);
        add(0, 0, 0, 1, 0, 2,   0, 1, 0);
        add(0, 0, 0, 0, 0, 2,   0, 1, 0);
        add(0, 0, 0, 1, 0, 2,   0, 0, 1);
        add(0, 0, 0, 0, 0, 2,   0, 0, 0);
        // stop on the would-be expiry cycle
        add(0, 1, 0, 1, 0, 1,   1, 1, 0);
        add(0, 0, 0, 1, 0, 1,   0, 1, 0);
        add(0, 0, 1, 1, 0, 1,   0, 0, 0);
        add(0, 0, 0, 1, 0, 1,   0, 0, 0);
        // start+stop together
        add(0, 1, 1, 1, 1, 5,   0, 0, 0);
        add(0, 0, 0, 1, 1, 5,   0, 0, 0);
        // restart while running
        add(0, 1, 0, 1, 0, 3,   3, 1, 0);
        add(0, 0, 0, 1, 0, 3,   2, 1, 0);
        add(0, 0, 0, 1, 0, 3,   1, 1, 0);
        add(0, 1, 0, 1, 0, 5,   5, 1, 0);
        add(0, 0, 0, 1, 0, 5,   4, 1, 0);
        // reset mid-run, periodic
        add(0, 1, 0, 1, 1, 2,   2, 1, 0);
        add(1, 0, 0, 1, 1, 2,   0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 1, 2, 0, 0, 0);
        // load 0 periodic: pulse on every enabled cycle
        add(0, 1, 0, 1, 1, 0,   0, 1, 0);
        add(0, 0, 0, 1, 1, 0,   0, 1, 1);
        add(0, 0, 0, 1, 1, 0,   0, 1, 1);
        add(0, 0, 0, 0, 1, 0,   0, 1, 0);
        add(0, 0, 0, 1, 1, 0,   0, 1, 1);
        add(0, 0, 1, 1, 1, 0,   0, 0, 0);
        // load 0 one-shot
        add(0, 1, 0, 1, 0, 0,   0, 1, 0);
        add(0, 0, 0, 0, 0, 0,   0, 1, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0, 1);
        add(0, 0, 0, 1, 0, 0,   0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].per, vecs[i].load);
            x.idx = i; x.cnt = vecs[i].cnt; x.busy = vecs[i].busy; x.done = vecs[i].done;
            sb.push_back(x);
            @(posedge clk_i);
            #1;
            x = sb.pop_front();
            check("count", x.idx, int'(bus.count), int'(x.cnt));
            check("busy",  x.idx, int'(bus.busy),  int'(x.busy));
            check("done",  x.idx, int'(bus.done),  int'(x.done));
        end

        // periodic load 4: pulses after 5 and 10 enabled cycles
        drive(0, 1, 0, 0, 1, 8'd4);
        @(posedge clk_i);
        first_done = 0;
        second_done = 0;
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, 0, 1, 0, 8'd9);
            @(posedge clk_i);
            #1;
            if (bus.done) begin
                if (first_done == 0) first_done = n;
                else if (second_done == 0) second_done = n;
            end
        end
        check("first_done_cycle", 1000, first_done, 5);
        check("second_done_cycle", 1001, second_done, 10);
        check("periodic_busy", 1002, int'(bus.busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counting timer with a start/stop control interface and a registered expiry pulse.
- Counts down rather than up, and loads its terminal value at start instead of comparing against it.
- Used for game-tick and event timing: snake move interval, food respawn delay, VGA-side delays.
- Supports one-shot and periodic (auto-reload) modes; a periodic timer with load_value=N expires every N+1 enabled cycles.

Parameters:
- dwidth, 8, width of load_value and count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable / tick qualifier; counting advances only on cycles with en=1.
- start  input  1  one-cycle request: latch load_value, begin running. Restarts if already running.
- stop  input  1  one-cycle request: abort, return to IDLE without expiry.
- periodic  input  1  mode select, sampled with start: 1 = auto-reload, 0 = one-shot.
- load_value  input  dwidth  initial/reload count, sampled only on an accepted start.
- count  output  dwidth  current remaining count.
- busy  output  1  high while in RUN.
- done  output  1  registered one-cycle pulse on each expiry.

Behaviour:
- Reset (synchronous, highest priority) clears all state:
  - state=IDLE, count=0, busy=0, done=0.
  - Internal reload register and mode bit cleared.
- State machine has two states, IDLE and RUN. busy = (state==RUN), decoded from the state register.
- Priority per cycle: reset > stop > start > counting.
- Internal registers:
  - reload_q (dwidth bits) and mode_q (1 bit), written only on an accepted start.
  - load_value/periodic changes while running are ignored until the next start.
- start (stop=0), from any state:
  - Next cycle: state=RUN, count=load_value, reload_q=load_value, mode_q=periodic, done=0.
  - en is ignored in the start cycle.
- stop (any state): next cycle state=IDLE, count holds its current value, done=0.
- stop and start in the same cycle: stop wins; start is dropped.
- RUN, en=0: count, state and done-generation frozen; done=0 next cycle.
- RUN, en=1, count!=0: count <= count-1.
- RUN, en=1, count==0 (expiry):
  - done=1 for exactly the next cycle.
  - mode_q=1: count <= reload_q, stay RUN.
  - mode_q=0: state <= IDLE, count stays 0.
- Expiry timing: after start, the first done asserts after exactly reload_q+1 enabled cycles in RUN.
- load_value=0: expiry occurs on the first enabled RUN cycle.
  - Periodic mode with load_value=0 pulses done on every enabled cycle.
- IDLE: count holds its value, en ignored, done=0.
- Arithmetic: the decrement never wraps, because the count==0 case is handled explicitly. No saturation logic is needed.
- done is a flop output, never combinational from inputs. done=0 in every cycle that is not immediately after an expiry.
- Reset asserted mid-run: RUN is aborted, no done pulse is issued, and the latched reload/mode is lost.

Test Plan:
- Reset, then hold 5 cycles with en=1 and no start -> count=0, busy=0, done=0 throughout.
- One-shot: start, load_value=3, periodic=0, en=1 continuous -> count 3,2,1,0 on cycles 1-4. Cycle 5: done=1, busy=0. Cycle 6 onward: done=0, count=0.
- Periodic: start, load_value=2, periodic=1, en=1 -> done pulses on cycles 4, 7, 10 (period 3). busy stays 1. Change load_value to 7 mid-run -> period unchanged.
- en gating: start, load_value=2, en alternating 1/0 -> count decrements only on en=1 cycles; done fires after the 3rd enabled cycle.
- Control collisions:
  - stop in the cycle where count==0 and en=1 -> no done, IDLE.
  - start+stop together -> IDLE.
  - start while RUN, count=1, load_value=5 -> count=5 next cycle, no done.
- Reset mid-run at count=2 (periodic) -> next cycle IDLE, count=0, done=0. No further pulses until a new start.
